// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
// Optional feature macro: MC_CTRL_TRAP_EN (adds the TRAP state).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    RST      = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9
`ifdef MC_CTRL_TRAP_EN
    , TRAP   = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational map from FSM state (plus mem_ready / zero) to datapath controls.
// Optional feature macro: MC_CTRL_TRAP_EN (drives illegal_instr in TRAP).
module mc_ctrl_outputs
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       illegal_instr
);

  // Per-state control decode; everything defaults to 0.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_src        = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
`ifdef MC_CTRL_TRAP_EN
      TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: state register, next-state
// logic and retired-instruction counter. Outputs come from mc_ctrl_outputs.
// Optional feature macro: MC_CTRL_TRAP_EN (illegal opcodes trap instead of NOP).
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  state_t state;
  state_t state_next;
  logic   retire;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST;
    else       state <= state_next;
  end

  // Next-state selection and retire strobe.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      RST:      state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_next = MEM_ADDR;
        else if (opcode == OP_R)                     state_next = EXEC_R;
        else if (opcode == OP_BRANCH)                state_next = BRANCH;
        else begin
`ifdef MC_CTRL_TRAP_EN
          state_next = TRAP;
`else
          state_next = FETCH;
          retire     = 1'b1;
`endif
        end
      end
      MEM_ADDR: state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
      MEM_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      EXEC_R:   state_next = R_WB;
      R_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
`ifdef MC_CTRL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = RST;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  assign state_o = state;

  mc_ctrl_outputs u_outputs (
    .state         (state),
    .mem_ready     (mem_ready),
    .zero          (zero),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal_instr (illegal_instr)
  );

endmodule
